multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle MIPS control unit; successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, drives per-state strobes and registered control levels, and handshakes with a variable-latency memory.
- Adds parametrised ALUOp width and memory timeout, stall, access sizing, jal/jr support and illegal-opcode reporting.
- Sits between the instruction register and the multi-cycle datapath.

Parameters:
ALUOP_W, 4, width of ALUOp (minimum 4)
MEM_TIMEOUT, 15, max consecutive MemReady-low cycles in FETCH/MEM before ERR; 0 disables timeout
TO_W, 4, timeout counter width (must hold MEM_TIMEOUT)

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Instruction  in  32  IR contents; sampled only in DECODE
Stall  in  1  freeze FSM and suppress strobes
MemReady  in  1  memory completed current access this cycle
State  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=7
IRWrite, PCWrite  out  1  strobes: IR load, PC+4 update
MemRead, MemWrite  out  1  memory request, held until MemReady
MemSize  out  2  0 word, 1 half, 2 byte
RegWrite  out  1  one-cycle strobe in WB
RegDst  out  2  0 rt, 1 rd, 2 $31
ALUSource  out  1  0 register, 1 immediate
MemToReg  out  2  0 memory, 1 ALU, 2 PC+4
BranchJump  out  2  0 none, 1 cond branch, 2 jump target, 3 jump register
ALUOp  out  ALUOP_W  0 funct, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 slt, 7 sltu, 8 lui, 9 special2, 10 special3
IllegalOp  out  1  one-cycle pulse in DECODE on unknown opcode
Err  out  1  sticky timeout flag

Behaviour:
- Reset (async, Reset_n=0): State=FETCH, every output 0, timeout counter 0, decode registers 0.
- FETCH: MemRead=1, MemSize=0. On MemReady: IRWrite=1 and PCWrite=1 for that cycle only, next=DECODE.
- DECODE: register opcode class from Instruction[31:26], Instruction[20:16] (REGIMM) and Instruction[5:0] (jr = R-type funct 001000). Levels RegDst/ALUSource/MemToReg/MemSize/ALUOp/BranchJump update at the end of this cycle and hold until next DECODE.
- DECODE, unknown opcode: IllegalOp=1 one cycle, next=FETCH, no writes.
- Decode table:
  - R-type: RegDst=1, MemToReg=1, ALUOp=0.
  - addi/addiu/andi/ori/xori/slti/sltiu: RegDst=0, ALUSource=1, MemToReg=1, ALUOp=1/1/3/4/5/6/7.
  - lui: ALUOp=8, ALUSource=1.
  - lw/lh/lb: MemToReg=0, ALUSource=1, ALUOp=1, MemSize=0/1/2.
  - sw/sh/sb: same ALUOp and MemSize, no write-back.
  - beq/bne/blez/bgtz/REGIMM bltz,bgez: BranchJump=1, ALUOp=2.
  - j: BranchJump=2.
  - jal: BranchJump=2, RegDst=2, MemToReg=2.
  - jr: BranchJump=3.
  - special2 (011100): ALUOp=9, RegDst=1. special3 (011111): ALUOp=10, RegDst=1.
- EXEC: one cycle.
  - Loads/stores -> MEM.
  - Branch, j, jr -> FETCH.
  - jal and ALU classes -> WB.
- MEM: MemRead (load) or MemWrite (store) held high until MemReady. Load -> WB; store -> FETCH.
- WB: RegWrite=1 one cycle -> FETCH.
- Minimum latency, FETCH to next FETCH, with MemReady immediate: ALU 4, load 5, store 4, branch/jump 3, jal 4.
- Stall=1:
  - State, decode registers and timeout counter hold.
  - IRWrite, PCWrite, RegWrite, MemRead, MemWrite forced 0.
  - MemReady ignored; an in-flight MEM access is re-issued when Stall falls.
- Timeout: counter increments each non-stalled FETCH/MEM cycle with MemReady=0 and clears on MemReady or state exit. When counter reaches MEM_TIMEOUT, next=ERR.
- ERR: all strobes 0, Err=1. ERR is left only by reset.
- Instruction changes outside DECODE have no effect.

Test Plan:
- Reset_n low mid-MEM of lw -> within same cycle State=0, all outputs 0; after release FETCH with MemRead=1.
- add (opcode 0, funct 100000), MemReady always 1 -> states 0,1,2,4,0; RegDst=1, ALUOp=0, RegWrite high exactly in cycle 4.
- lh with MemReady delayed 3 cycles in MEM -> MemRead=1 for 4 MEM cycles, MemSize=1, then WB with RegWrite=1; total 8 cycles.
- jal then jr ($31) -> jal: BranchJump=2, RegDst=2, MemToReg=2, RegWrite in WB; jr: BranchJump=3, no RegWrite, 3 cycles.
- Opcode 111111 -> IllegalOp pulse in DECODE, next state 0, no RegWrite/MemWrite.
- MEM_TIMEOUT=15, MemReady stuck 0 in FETCH with Stall toggling -> ERR reached after exactly 15 non-stalled cycles; Err stays 1 until Reset_n low.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// registered decode levels, stall, variable-latency memory handshake and timeout.
module multicycle_controller #(
   parameter int ALUOP_W     = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 4
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [31:0]        Instruction,
   input  logic               Stall,
   input  logic               MemReady,
   output logic [2:0]         State,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic [1:0]         MemSize,
   output logic               RegWrite,
   output logic [1:0]         RegDst,
   output logic               ALUSource,
   output logic [1:0]         MemToReg,
   output logic [1:0]         BranchJump,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               IllegalOp,
   output logic               Err
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
      S_MEM = 3'd3, S_WB = 3'd4, S_ERR = 3'd7
   } state_t;

   // C_ALU covers every class that ends in write-back, including jal
   typedef enum logic [1:0] {C_ALU, C_LOAD, C_STORE, C_CTRL} cls_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t              state_q, state_d;
   logic [TO_W-1:0]     cnt_q, cnt_d;
   cls_t                cls_q, cls_d, d_cls;
   logic [1:0]          rd_q, rd_d, d_rd;
   logic                src_q, src_d, d_src;
   logic [1:0]          m2r_q, m2r_d, d_m2r;
   logic [1:0]          sz_q, sz_d, d_sz;
   logic [1:0]          bj_q, bj_d, d_bj;
   logic [ALUOP_W-1:0]  aop_q, aop_d, d_aop;
   logic                d_legal;
   logic                to_hit;

   logic [5:0] op, fn;
   logic [4:0] rt;
   logic       unused_ir;

   assign op        = Instruction[31:26];
   assign rt        = Instruction[20:16];
   assign fn        = Instruction[5:0];
   assign unused_ir = ^{Instruction[25:21], Instruction[15:6]};

   always_comb begin
      d_cls = C_ALU; d_rd = 2'd0; d_src = 1'b0; d_m2r = 2'd0;
      d_sz = 2'd0; d_bj = 2'd0; d_aop = '0; d_legal = 1'b1;
      case (op)
         6'b000000: begin
            if (fn == 6'b001000) begin
               d_cls = C_CTRL; d_bj = 2'd3;
            end else begin
               d_rd = 2'd1; d_m2r = 2'd1;
            end
         end
         6'b000001: begin
            if (rt == 5'd0 || rt == 5'd1) begin
               d_cls = C_CTRL; d_bj = 2'd1; d_aop = ALUOP_W'(2);
            end else begin
               d_legal = 1'b0;
            end
         end
         6'b000010: begin d_cls = C_CTRL; d_bj = 2'd2; end
         6'b000011: begin d_bj = 2'd2; d_rd = 2'd2; d_m2r = 2'd2; end
         6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
            d_cls = C_CTRL; d_bj = 2'd1; d_aop = ALUOP_W'(2);
         end
         6'b001000, 6'b001001: begin d_src = 1'b1; d_m2r = 2'd1; d_aop = ALUOP_W'(1); end
         6'b001010: begin d_src = 1'b1; d_m2r = 2'd1; d_aop = ALUOP_W'(6); end
         6'b001011: begin d_src = 1'b1; d_m2r = 2'd1; d_aop = ALUOP_W'(7); end
         6'b001100: begin d_src = 1'b1; d_m2r = 2'd1; d_aop = ALUOP_W'(3); end
         6'b001101: begin d_src = 1'b1; d_m2r = 2'd1; d_aop = ALUOP_W'(4); end
         6'b001110: begin d_src = 1'b1; d_m2r = 2'd1; d_aop = ALUOP_W'(5); end
         6'b001111: begin d_src = 1'b1; d_m2r = 2'd1; d_aop = ALUOP_W'(8); end
         6'b100011: begin d_cls = C_LOAD; d_src = 1'b1; d_aop = ALUOP_W'(1); d_sz = 2'd0; end
         6'b100001: begin d_cls = C_LOAD; d_src = 1'b1; d_aop = ALUOP_W'(1); d_sz = 2'd1; end
         6'b100000: begin d_cls = C_LOAD; d_src = 1'b1; d_aop = ALUOP_W'(1); d_sz = 2'd2; end
         6'b101011: begin d_cls = C_STORE; d_src = 1'b1; d_aop = ALUOP_W'(1); d_sz = 2'd0; end
         6'b101001: begin d_cls = C_STORE; d_src = 1'b1; d_aop = ALUOP_W'(1); d_sz = 2'd1; end
         6'b101000: begin d_cls = C_STORE; d_src = 1'b1; d_aop = ALUOP_W'(1); d_sz = 2'd2; end
         6'b011100: begin d_rd = 2'd1; d_m2r = 2'd1; d_aop = ALUOP_W'(9); end
         6'b011111: begin d_rd = 2'd1; d_m2r = 2'd1; d_aop = ALUOP_W'(10); end
         default:   d_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q; cnt_d = cnt_q;
      cls_d = cls_q; rd_d = rd_q; src_d = src_q; m2r_d = m2r_q;
      sz_d = sz_q; bj_d = bj_q; aop_d = aop_q;
      IRWrite = 1'b0; PCWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      RegWrite = 1'b0; IllegalOp = 1'b0;
      to_hit = (MEM_TIMEOUT != 0) && (cnt_q == TO_LAST);
      if (!Stall) begin
         case (state_q)
            S_FETCH, S_MEM: begin
               if (MemReady) begin
                  cnt_d = '0;
                  if (state_q == S_FETCH)     state_d = S_DECODE;
                  else if (cls_q == C_LOAD)   state_d = S_WB;
                  else                        state_d = S_FETCH;
               end else if (to_hit) begin
                  cnt_d = '0; state_d = S_ERR;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_DECODE: begin
               if (d_legal) begin
                  cls_d = d_cls; rd_d = d_rd; src_d = d_src; m2r_d = d_m2r;
                  sz_d = d_sz; bj_d = d_bj; aop_d = d_aop;
                  state_d = S_EXEC;
               end else begin
                  state_d = S_FETCH;
               end
            end
            S_EXEC: begin
               case (cls_q)
                  C_LOAD, C_STORE: state_d = S_MEM;
                  C_CTRL:          state_d = S_FETCH;
                  default:         state_d = S_WB;
               endcase
            end
            S_WB:    state_d = S_FETCH;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
         endcase
      end
      // strobes are gated by Reset_n so they drop within the reset cycle
      if (Reset_n && !Stall) begin
         case (state_q)
            S_FETCH:  begin MemRead = 1'b1; IRWrite = MemReady; PCWrite = MemReady; end
            S_DECODE: IllegalOp = !d_legal;
            S_MEM:    begin MemRead = (cls_q == C_LOAD); MemWrite = (cls_q == C_STORE); end
            S_WB:     RegWrite = 1'b1;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_FETCH; cnt_q <= '0; cls_q <= C_ALU;
         rd_q <= '0; src_q <= 1'b0; m2r_q <= '0; sz_q <= '0; bj_q <= '0; aop_q <= '0;
      end else begin
         state_q <= state_d; cnt_q <= cnt_d; cls_q <= cls_d;
         rd_q <= rd_d; src_q <= src_d; m2r_q <= m2r_d; sz_q <= sz_d; bj_q <= bj_d; aop_q <= aop_d;
      end
   end

   assign State      = state_q;
   assign Err        = (state_q == S_ERR);
   assign MemSize    = (state_q == S_FETCH) ? 2'd0 : sz_q;
   assign RegDst     = rd_q;
   assign ALUSource  = src_q;
   assign MemToReg   = m2r_q;
   assign BranchJump = bj_q;
   assign ALUOp      = aop_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is modelled as a
// list of phases derived from its class, with random memory latency and stalls.
module tb_multicycle_controller;

   localparam logic [2:0] K_ALU = 3'd0, K_LD = 3'd1, K_ST = 3'd2, K_BR = 3'd3,
                          K_JAL = 3'd4, K_ILL = 3'd5;

   typedef struct packed {
      logic [5:0] op; logic [4:0] rt; logic [5:0] fn; logic [2:0] cls;
      logic [1:0] rd; logic src; logic [1:0] m2r; logic [1:0] sz; logic [1:0] bj; logic [3:0] aop;
   } ent_t;

   logic        Clk, Reset_n, Stall, MemReady;
   logic [31:0] Instruction;
   logic [2:0]  State;
   logic        IRWrite, PCWrite, MemRead, MemWrite, RegWrite, ALUSource, IllegalOp, Err;
   logic [1:0]  MemSize, RegDst, MemToReg, BranchJump;
   logic [3:0]  ALUOp;

   int          vecs, errs;
   logic [12:0] lv;  // expected {RegDst,ALUSource,MemToReg,MemSize,BranchJump,ALUOp}

   multicycle_controller #(.ALUOP_W(4), .MEM_TIMEOUT(15), .TO_W(4)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Instruction(Instruction), .Stall(Stall),
      .MemReady(MemReady), .State(State), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .RegWrite(RegWrite),
      .RegDst(RegDst), .ALUSource(ALUSource), .MemToReg(MemToReg),
      .BranchJump(BranchJump), .ALUOp(ALUOp), .IllegalOp(IllegalOp), .Err(Err)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   //                  op        rt     fn         cls    rd    src   m2r   sz    bj    aop
   function automatic ent_t ent(input int i);
      case (i)
         0:  return {6'o00, 5'd0, 6'b100000, K_ALU, 2'd1, 1'b0, 2'd1, 2'd0, 2'd0, 4'd0};
         1:  return {6'b001000, 5'd0, 6'd0, K_ALU, 2'd0, 1'b1, 2'd1, 2'd0, 2'd0, 4'd1};
         2:  return {6'b001001, 5'd0, 6'd0, K_ALU, 2'd0, 1'b1, 2'd1, 2'd0, 2'd0, 4'd1};
         3:  return {6'b001100, 5'd0, 6'd0, K_ALU, 2'd0, 1'b1, 2'd1, 2'd0, 2'd0, 4'd3};
         4:  return {6'b001101, 5'd0, 6'd0, K_ALU, 2'd0, 1'b1, 2'd1, 2'd0, 2'd0, 4'd4};
         5:  return {6'b001110, 5'd0, 6'd0, K_ALU, 2'd0, 1'b1, 2'd1, 2'd0, 2'd0, 4'd5};
         6:  return {6'b001010, 5'd0, 6'd0, K_ALU, 2'd0, 1'b1, 2'd1, 2'd0, 2'd0, 4'd6};
         7:  return {6'b001011, 5'd0, 6'd0, K_ALU, 2'd0, 1'b1, 2'd1, 2'd0, 2'd0, 4'd7};
         8:  return {6'b001111, 5'd0, 6'd0, K_ALU, 2'd0, 1'b1, 2'd1, 2'd0, 2'd0, 4'd8};
         9:  return {6'b100011, 5'd0, 6'd0, K_LD,  2'd0, 1'b1, 2'd0, 2'd0, 2'd0, 4'd1};
         10: return {6'b100001, 5'd0, 6'd0, K_LD,  2'd0, 1'b1, 2'd0, 2'd1, 2'd0, 4'd1};
         11: return {6'b100000, 5'd0, 6'd0, K_LD,  2'd0, 1'b1, 2'd0, 2'd2, 2'd0, 4'd1};
         12: return {6'b101011, 5'd0, 6'd0, K_ST,  2'd0, 1'b1, 2'd0, 2'd0, 2'd0, 4'd1};
         13: return {6'b101001, 5'd0, 6'd0, K_ST,  2'd0, 1'b1, 2'd0, 2'd1, 2'd0, 4'd1};
         14: return {6'b101000, 5'd0, 6'd0, K_ST,  2'd0, 1'b1, 2'd0, 2'd2, 2'd0, 4'd1};
         15: return {6'b000100, 5'd0, 6'd0, K_BR,  2'd0, 1'b0, 2'd0, 2'd0, 2'd1, 4'd2};
         16: return {6'b000101, 5'd0, 6'd0, K_BR,  2'd0, 1'b0, 2'd0, 2'd0, 2'd1, 4'd2};
         17: return {6'b000110, 5'd0, 6'd0, K_BR,  2'd0, 1'b0, 2'd0, 2'd0, 2'd1, 4'd2};
         18: return {6'b000111, 5'd0, 6'd0, K_BR,  2'd0, 1'b0, 2'd0, 2'd0, 2'd1, 4'd2};
         19: return {6'b000001, 5'd0, 6'd0, K_BR,  2'd0, 1'b0, 2'd0, 2'd0, 2'd1, 4'd2};
         20: return {6'b000001, 5'd1, 6'd0, K_BR,  2'd0, 1'b0, 2'd0, 2'd0, 2'd1, 4'd2};
         21: return {6'b000010, 5'd0, 6'd0, K_BR,  2'd0, 1'b0, 2'd0, 2'd0, 2'd2, 4'd0};
         22: return {6'b000011, 5'd0, 6'd0, K_JAL, 2'd2, 1'b0, 2'd2, 2'd0, 2'd2, 4'd0};
         23: return {6'b000000, 5'd0, 6'b001000, K_BR, 2'd0, 1'b0, 2'd0, 2'd0, 2'd3, 4'd0};
         24: return {6'b011100, 5'd0, 6'd0, K_ALU, 2'd1, 1'b0, 2'd1, 2'd0, 2'd0, 4'd9};
         25: return {6'b011111, 5'd0, 6'd0, K_ALU, 2'd1, 1'b0, 2'd1, 2'd0, 2'd0, 4'd10};
         26: return {6'b111111, 5'd0, 6'd0, K_ILL, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 4'd0};
         27: return {6'b010000, 5'd0, 6'd0, K_ILL, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 4'd0};
         28: return {6'b000001, 5'd2, 6'd0, K_ILL, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 4'd0};
         default: return {6'b110011, 5'd0, 6'd0, K_ILL, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 4'd0};
      endcase
   endfunction

   // expected strobes {IRWrite,PCWrite,MemRead,MemWrite,RegWrite,IllegalOp,Err} for a live cycle
   function automatic logic [6:0] stb(input logic [2:0] ph, input logic rdy, input logic [2:0] cls);
      case (ph)
         3'd0:    return {rdy, rdy, 1'b1, 4'b0000};
         3'd1:    return {5'b00000, cls == K_ILL, 1'b0};
         3'd3:    return {2'b00, cls == K_LD, cls == K_ST, 3'b000};
         3'd4:    return 7'b0000100;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic cyc(input logic st, input logic rdy, input logic [31:0] instr,
                      input logic [2:0] es, input logic [6:0] estb);
      logic [12:0] el;
      @(negedge Clk);
      Stall = st; MemReady = rdy; Instruction = instr;
      #2;
      el = lv;
      if (es == 3'd0) el[7:6] = 2'd0;
      check("state", 32'(State), 32'(es));
      check("strobes", 32'({IRWrite, PCWrite, MemRead, MemWrite, RegWrite, IllegalOp, Err}), 32'(estb));
      check("levels", 32'({RegDst, ALUSource, MemToReg, MemSize, BranchJump, ALUOp}), 32'(el));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, 32'(State), 32'd0);
      check({tag, "_outs"}, 32'({IRWrite, PCWrite, MemRead, MemWrite, MemSize, RegWrite, RegDst,
                                ALUSource, MemToReg, BranchJump, ALUOp, IllegalOp, Err}), 32'd0);
   endtask

   task automatic release_reset();
      @(posedge Clk);
      #1 Reset_n = 1'b1;
   endtask

   // fd/md: FETCH/MEM MemReady delay in live cycles (<0 = random); stalls enables random Stall
   task automatic run_instr(input int idx, input int fd, input int md, input logic stalls);
      ent_t        e;
      logic [31:0] w, iw;
      logic [2:0]  ph[5];
      int          np, d, n;
      logic        done, st;
      e = ent(idx);
      w = $urandom;
      w[31:26] = e.op;
      if (e.op == 6'd0) w[5:0] = e.fn;
      if (e.op == 6'd1) w[20:16] = e.rt;
      if (idx == 0) begin
         w[5:0] = 6'($urandom);
         if (w[5:0] == 6'b001000) w[5:0] = 6'b100000;
      end
      ph[0] = 3'd0; ph[1] = 3'd1; ph[2] = 3'd2; ph[3] = 3'd4; ph[4] = 3'd4;
      case (e.cls)
         K_LD:    begin ph[3] = 3'd3; np = 5; end
         K_ST:    begin ph[3] = 3'd3; np = 4; end
         K_BR:    np = 3;
         K_ILL:   np = 2;
         default: np = 4;
      endcase
      for (int p = 0; p < np; p++) begin
         if (ph[p] == 3'd0 || ph[p] == 3'd3) begin
            d = (ph[p] == 3'd0) ? fd : md;
            if (d < 0) d = int'($urandom_range(0, 3));
            n = 0; done = 1'b0;
            for (int k = 0; k < 64 && !done; k++) begin
               st = stalls && k < 8 && ($urandom_range(0, 3) == 0);
               iw = $urandom;
               if (st) cyc(1'b1, 1'($urandom_range(0, 1)), iw, ph[p], 7'd0);
               else if (n < d) begin
                  cyc(1'b0, 1'b0, iw, ph[p], stb(ph[p], 1'b0, e.cls));
                  n++;
               end else begin
                  cyc(1'b0, 1'b1, iw, ph[p], stb(ph[p], 1'b1, e.cls));
                  done = 1'b1;
               end
            end
            if (!done) check("mem_phase_bound", 32'd0, 32'd1);
         end else begin
            iw = (ph[p] == 3'd1) ? w : $urandom;
            for (int k = 0; k < 4 && stalls && $urandom_range(0, 3) == 0; k++)
               cyc(1'b1, 1'($urandom_range(0, 1)), iw, ph[p], 7'd0);
            cyc(1'b0, 1'($urandom_range(0, 1)), iw, ph[p], stb(ph[p], 1'b0, e.cls));
            if (ph[p] == 3'd1 && e.cls != K_ILL) lv = {e.rd, e.src, e.m2r, e.sz, e.bj, e.aop};
         end
      end
   endtask

   initial begin
      ent_t e;
      logic [31:0] w;
      logic st;
      int n;
      vecs = 0; errs = 0; lv = '0;
      Reset_n = 1'b0; Stall = 1'b0; MemReady = 1'b0; Instruction = '0;
      repeat (2) @(negedge Clk);
      #1 check_reset_outputs("reset");
      release_reset();

      run_instr(0, 0, 0, 1'b0);    // add: 0,1,2,4
      run_instr(10, 0, 3, 1'b0);   // lh with 3-cycle MEM delay: 8 cycles
      run_instr(22, 0, 0, 1'b0);   // jal
      run_instr(23, 0, 0, 1'b0);   // jr
      run_instr(26, 0, 0, 1'b0);   // illegal 111111
      run_instr(12, 2, 1, 1'b0);   // sw

      // reset in the middle of a lw MEM phase
      e = ent(9);
      w = $urandom; w[31:26] = e.op;
      cyc(1'b0, 1'b1, $urandom, 3'd0, stb(3'd0, 1'b1, K_LD));
      cyc(1'b0, 1'b0, w, 3'd1, 7'd0);
      lv = {e.rd, e.src, e.m2r, e.sz, e.bj, e.aop};
      cyc(1'b0, 1'b0, $urandom, 3'd2, 7'd0);
      cyc(1'b0, 1'b0, $urandom, 3'd3, stb(3'd3, 1'b0, K_LD));
      @(negedge Clk);
      MemReady = 1'b0; Stall = 1'b0;
      #2 Reset_n = 1'b0;
      #1 check_reset_outputs("midmem_reset");
      lv = '0;
      @(posedge Clk);
      release_reset();
      run_instr(9, 0, 0, 1'b0);

      for (int i = 0; i < 200; i++) run_instr(int'($urandom_range(0, 29)), -1, -1, 1'b1);

      // timeout: MemReady stuck low in FETCH with Stall toggling
      n = 0;
      for (int k = 0; k < 200 && n < 15; k++) begin
         st = 1'($urandom_range(0, 1));
         if (st) cyc(1'b1, 1'($urandom_range(0, 1)), $urandom, 3'd0, 7'd0);
         else begin
            cyc(1'b0, 1'b0, $urandom, 3'd0, 7'b0010000);
            n++;
         end
      end
      check("timeout_cycles", 32'(n), 32'd15);
      for (int k = 0; k < 6; k++)
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 3'd7, 7'b0000001);
      @(negedge Clk);
      #2 Reset_n = 1'b0;
      #1 check_reset_outputs("err_reset");
      lv = '0;
      release_reset();
      run_instr(1, 0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
